// File: rtl/hydra_pkg.sv
// ----------------------------------------------------------------------------
// hydra_pkg
//   Shared constants and types for the per-port dequeue scheduler.
//   NUM_PRI  : priority queues per output port (index 0 = highest priority)
//   PRI_W    : width of a queue index
//   LEN_W    : packet length field width, in 16-bit beats (1..256)
//   WEIGHT_W : width of one WRR weight / credit counter
// ----------------------------------------------------------------------------
package hydra_pkg;

    localparam int NUM_PRI  = 8;
    localparam int PRI_W    = $clog2(NUM_PRI);
    localparam int LEN_W    = 9;
    localparam int WEIGHT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RELOAD = 2'd1,
        GRANT  = 2'd2,
        BUSY   = 2'd3
    } sched_state_t;

    // A programmed weight of zero would starve its queue forever under WRR,
    // so it is promoted to one credit per round.
    function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [WEIGHT_W-1:0] w);
        return (w == '0) ? WEIGHT_W'(1) : w;
    endfunction

endpackage

// File: rtl/pri_first_one.sv
// ----------------------------------------------------------------------------
// pri_first_one
//   Combinational lowest-index-set encoder. Bit 0 wins over every other bit,
//   which matches "index 0 = highest priority" for the queue vectors.
// Ports
//   i_vec : request vector
//   o_idx : index of the lowest set bit (0 when i_vec is all-zero)
//   o_vld : at least one bit of i_vec is set
// ----------------------------------------------------------------------------
module pri_first_one
    import hydra_pkg::*;
#(
    parameter int N  = NUM_PRI,
    parameter int IW = PRI_W
) (
    input  logic [N-1:0]  i_vec,
    output logic [IW-1:0] o_idx,
    output logic          o_vld
);

    // w_lower[gi] is set when any bit below gi is set; the first one is the
    // only set bit whose lower-prefix is clear.
    logic [N-1:0] w_lower;
    logic [N-1:0] w_onehot;

    assign w_lower[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < N; gi++) begin : g_prefix
            assign w_lower[gi] = w_lower[gi-1] | i_vec[gi-1];
        end
        for (gi = 0; gi < N; gi++) begin : g_onehot
            assign w_onehot[gi] = i_vec[gi] & ~w_lower[gi];
        end
    endgenerate

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (w_onehot[i]) begin
                o_idx = o_idx | IW'(i);
            end
        end
    end

    assign o_vld = |i_vec;

endmodule

// File: rtl/port_wrr_scheduler.sv
// ----------------------------------------------------------------------------
// port_wrr_scheduler
//   Per-output-port dequeue scheduler. Picks one priority queue per packet,
//   requests its head from the queue manager, then counts the packet's beats
//   and blocks the next grant until the whole packet has left.
//   wrr_en=0 : strict priority (lowest non-empty index).
//   wrr_en=1 : credit-based weighted round robin; each grant spends one
//              credit of the chosen queue, credits are refilled from the
//              weights when no non-empty queue has credit left.
// Ports
//   clk            : clock, all logic on posedge
//   rst            : synchronous active-high reset
//   wrr_en         : mode select, sampled only at the IDLE decision
//   weight         : NUM_PRI packed WEIGHT_W-bit weights (queue 0 in LSBs)
//   queue_nonempty : bit p set when queue p holds at least one packet
//   ready          : downstream port can start a new packet
//   deq_vld        : dequeue request for the head of queue deq_pri
//   deq_pri        : selected queue index
//   deq_ack        : queue manager accepted the request
//   pkt_len        : packet length in beats, valid with deq_ack (0 -> 1)
//   beat_vld       : one beat of the current packet was sent
//   busy           : a packet is in progress (GRANT or BUSY)
// ----------------------------------------------------------------------------
module port_wrr_scheduler
    import hydra_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wrr_en,
    input  logic [NUM_PRI*WEIGHT_W-1:0] weight,
    input  logic [NUM_PRI-1:0]          queue_nonempty,
    input  logic                        ready,
    output logic                        deq_vld,
    output logic [PRI_W-1:0]            deq_pri,
    input  logic                        deq_ack,
    input  logic [LEN_W-1:0]            pkt_len,
    input  logic                        beat_vld,
    output logic                        busy
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    sched_state_t          r_state;
    sched_state_t          w_state_next;
    logic [WEIGHT_W-1:0]   r_credit      [NUM_PRI];
    logic [WEIGHT_W-1:0]   w_credit_next [NUM_PRI];
    logic [LEN_W-1:0]      r_cnt;
    logic [LEN_W-1:0]      w_cnt_next;
    logic                  r_reload_pending;
    logic                  w_reload_pending_next;
    logic [PRI_W-1:0]      r_sel;
    logic [PRI_W-1:0]      w_sel_next;
    // Mode of the packet in flight; the credit is charged on the ack using
    // the mode that made the decision, not whatever wrr_en is by then.
    logic                  r_wrr_mode;
    logic                  w_wrr_mode_next;

    // ------------------------------------------------------------------
    // Per-queue views of the weights and credits
    // ------------------------------------------------------------------
    logic [WEIGHT_W-1:0]   w_weight [NUM_PRI];
    logic [NUM_PRI-1:0]    w_credit_nz;
    logic [NUM_PRI-1:0]    w_elig;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PRI; gi++) begin : g_queue
            assign w_weight[gi]    = weight[gi*WEIGHT_W +: WEIGHT_W];
            assign w_credit_nz[gi] = (r_credit[gi] != '0);
        end
    endgenerate

    assign w_elig = queue_nonempty & w_credit_nz;

    // ------------------------------------------------------------------
    // Selection encoders: strict picks among all non-empty queues, WRR only
    // among non-empty queues that still hold credit.
    // ------------------------------------------------------------------
    logic [PRI_W-1:0] w_strict_idx;
    logic             w_strict_vld;
    logic [PRI_W-1:0] w_elig_idx;
    logic             w_elig_vld;

    pri_first_one #(
        .N  (NUM_PRI),
        .IW (PRI_W)
    ) u_strict_sel (
        .i_vec (queue_nonempty),
        .o_idx (w_strict_idx),
        .o_vld (w_strict_vld)
    );

    pri_first_one #(
        .N  (NUM_PRI),
        .IW (PRI_W)
    ) u_elig_sel (
        .i_vec (w_elig),
        .o_idx (w_elig_idx),
        .o_vld (w_elig_vld)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next          = r_state;
        w_cnt_next            = r_cnt;
        w_reload_pending_next = r_reload_pending;
        w_sel_next            = r_sel;
        w_wrr_mode_next       = r_wrr_mode;
        for (int p = 0; p < NUM_PRI; p++) begin
            w_credit_next[p] = r_credit[p];
        end

        case (r_state)
            IDLE: begin
                if (ready && w_strict_vld) begin
                    w_wrr_mode_next = wrr_en;
                    if (!wrr_en) begin
                        w_sel_next   = w_strict_idx;
                        w_state_next = GRANT;
                    end else if (!w_elig_vld || r_reload_pending) begin
                        // Nobody eligible (or first round after reset):
                        // refill, then come back here and decide again with
                        // the inputs current at that time.
                        w_state_next = RELOAD;
                    end else begin
                        w_sel_next   = w_elig_idx;
                        w_state_next = GRANT;
                    end
                end
            end

            RELOAD: begin
                for (int p = 0; p < NUM_PRI; p++) begin
                    w_credit_next[p] = eff_weight(w_weight[p]);
                end
                w_reload_pending_next = 1'b0;
                w_state_next          = IDLE;
            end

            GRANT: begin
                // Request held until accepted; queue/ready changes here do
                // not withdraw it.
                if (deq_ack) begin
                    w_cnt_next = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
                    if (r_wrr_mode && (r_credit[r_sel] != '0)) begin
                        w_credit_next[r_sel] = r_credit[r_sel] - WEIGHT_W'(1);
                    end
                    w_state_next = BUSY;
                end
            end

            BUSY: begin
                if (beat_vld) begin
                    // cnt is at least 1 on entry; treating <=1 as the last
                    // beat keeps the counter from ever wrapping.
                    if (r_cnt <= LEN_W'(1)) begin
                        w_cnt_next   = '0;
                        w_state_next = IDLE;
                    end else begin
                        w_cnt_next = r_cnt - LEN_W'(1);
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_cnt            <= '0;
            r_reload_pending <= 1'b1;
            r_sel            <= '0;
            r_wrr_mode       <= 1'b0;
            for (int p = 0; p < NUM_PRI; p++) begin
                r_credit[p] <= '0;
            end
        end else begin
            r_state          <= w_state_next;
            r_cnt            <= w_cnt_next;
            r_reload_pending <= w_reload_pending_next;
            r_sel            <= w_sel_next;
            r_wrr_mode       <= w_wrr_mode_next;
            for (int p = 0; p < NUM_PRI; p++) begin
                r_credit[p] <= w_credit_next[p];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded straight from registered state)
    // ------------------------------------------------------------------
    assign deq_vld = (r_state == GRANT);
    assign deq_pri = r_sel;
    assign busy    = (r_state == GRANT) || (r_state == BUSY);

endmodule
